// File: rtl/draw_pkg.sv
// Shared types and constants for the draw request scheduler.
package draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam int unsigned REQ_SCRN_START     = 0;
  localparam int unsigned REQ_SCRN_GAME_OVER = 1;
  localparam int unsigned REQ_SCRN_GAME_BG   = 2;
  localparam int unsigned REQ_FROG           = 3;

  localparam int unsigned NUM_REQ_DEFAULT        = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 131072;

  // Next round-robin start index after serving idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [IDW-1:0]     win_o,
  output logic               any_req_o
);

  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDW-1:0]     rot_win;
  logic [IDW:0]       sum;

  // Rotate so rr_ptr_i lands on bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot       = NUM_REQ'({req_i, req_i} >> rr_ptr_i);
    rot_win   = '0;
    any_req_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rot[i] && !any_req_o) begin
        rot_win   = IDW'(i);
        any_req_o = 1'b1;
      end
    end
    sum = {1'b0, rot_win} + {1'b0, rr_ptr_i};
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    win_o = sum[IDW-1:0];
  end

endmodule

// File: rtl/draw_scheduler.sv
// Grants the shared plotter datapath to one requester at a time, with ack,
// watchdog abort and a one-cycle re-arm gap between grants.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned IDW            = $clog2(NUM_REQ),
  parameter int unsigned TCW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               plot_done,
  output logic [NUM_REQ-1:0] draw_sel,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] ack,
  output logic               timeout_err
);

  state_e             state_q;
  logic [NUM_REQ-1:0] draw_sel_q;
  logic [IDW-1:0]     grant_id_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               timeout_err_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [TCW-1:0]     wd_q;

  logic [IDW-1:0]     win;
  logic               any_req;
  logic [NUM_REQ-1:0] win_oh_d;
  logic [IDW-1:0]     rr_ptr_d;
  logic               wd_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .win_o     (win),
    .any_req_o (any_req)
  );

  always_comb begin
    win_oh_d      = '0;
    win_oh_d[win] = 1'b1;
  end

  assign rr_ptr_d   = IDW'(wrap_inc(32'(grant_id_q), NUM_REQ));
  assign wd_expired = (wd_q == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      draw_sel_q    <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= '0;
      wd_q          <= '0;
    end else begin
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q     <= 1'b0;
          draw_sel_q <= '0;
          if (any_req) begin
            state_q    <= S_DRAW;
            draw_sel_q <= win_oh_d;
            grant_id_q <= win;
            busy_q     <= 1'b1;
            wd_q       <= '0;
          end
        end
        S_DRAW: begin
          // plot_done takes priority over a watchdog expiry in the same cycle.
          if (plot_done) begin
            ack_q      <= draw_sel_q;
            draw_sel_q <= '0;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= S_GAP;
          end else if (wd_expired) begin
            timeout_err_q <= 1'b1;
            draw_sel_q    <= '0;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= S_GAP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_GAP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          draw_sel_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign draw_sel    = draw_sel_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign ack         = ack_q;
  assign timeout_err = timeout_err_q;

endmodule
